// File: rtl/dram_cache_pkg.sv
// cache_defs: shared definitions for the dram_cache block.
//   cache_state_t : controller FSM encoding (IDLE / WBACK / FILL)
//   LINE_BYTES    : bytes per cache line; OFFW = byte-offset width
//   idx_w/tag_w   : index and tag widths derived from the line count
//   merge_word    : byte-strobed merge of one 32-bit word into a 128-bit line
package cache_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WBACK = 2'd1,
      FILL  = 2'd2
   } cache_state_t;

   localparam int LINE_BYTES = 16;
   localparam int OFFW       = $clog2(LINE_BYTES);

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int lines);
      return 32 - OFFW - $clog2(lines);
   endfunction

   // Byte 0 of the line sits in bits [7:0]; word wsel covers bytes 4*wsel..4*wsel+3.
   function automatic logic [127:0] merge_word(input logic [127:0] line,
                                               input logic [1:0]   wsel,
                                               input logic [3:0]   wstrb,
                                               input logic [31:0]  wdata);
      logic [127:0] r;
      r = line;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) r[{wsel, b[1:0], 3'b000} +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dram_cache_store.sv
// dram_cache_store: valid/dirty/tag/data arrays of the direct-mapped cache.
//   clk, clear        : clock; clear invalidates every line (valid and dirty)
//   idx               : line index shared by the read and write ports
//   rd_*              : combinational read of the indexed line
//   fill_en/tag/line  : write a whole line from DRAM (valid set, dirty cleared)
//   merge_en/wsel/... : byte-merge one word into the indexed line (dirty set)
module dram_cache_store
   import cache_defs::*;
#(
   parameter int LINES = 64,
   parameter int IDXW  = 6,
   parameter int TAGW  = 22
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [IDXW-1:0]  idx,
   output logic             rd_valid,
   output logic             rd_dirty,
   output logic [TAGW-1:0]  rd_tag,
   output logic [127:0]     rd_line,
   input  logic             fill_en,
   input  logic [TAGW-1:0]  fill_tag,
   input  logic [127:0]     fill_line,
   input  logic             merge_en,
   input  logic [1:0]       merge_wsel,
   input  logic [3:0]       merge_wstrb,
   input  logic [31:0]      merge_wdata
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAGW-1:0]  tag_q  [LINES];
   logic [127:0]     data_q [LINES];

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_line  = data_q[idx];

   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (merge_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Tag and data carry no reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[idx] <= fill_line;
         tag_q[idx]  <= fill_tag;
      end else if (merge_en) begin
         data_q[idx] <= merge_word(data_q[idx], merge_wsel, merge_wstrb, merge_wdata);
      end
   end

endmodule

// File: rtl/dram_cache.sv
// dram_cache: direct-mapped, write-back, write-allocate cache in front of the
// DDR3 controller. Converts 32-bit core accesses into 128-bit line transfers.
//   core side : valid/addr/wstrb/wdata in, ready (1-cycle pulse) / rdata out
//   mem side  : mem_valid/mem_addr/mem_wmask/mem_wdata out, mem_ready/mem_rdata in
//   dbg_state : current FSM state for observation
//
// Handshake: the core holds valid and its request fields until the one-cycle
// ready pulse; a request is accepted on any edge with valid && !ready. On the
// memory side mem_valid is held with stable fields until the one-cycle
// mem_ready pulse, and is dropped combinationally during that pulse.
module dram_cache
   import cache_defs::*;
#(
   parameter int LINES = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid,
   output logic          ready,
   input  logic [31:0]   addr,
   input  logic [3:0]    wstrb,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [31:0]   mem_addr,
   output logic          mem_wmask,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   output cache_state_t  dbg_state
);

   localparam int IDXW = idx_w(LINES);
   localparam int TAGW = tag_w(LINES);

   cache_state_t    state, state_n;
   logic            ready_n;
   logic [31:0]     rdata_n;
   logic            fill_en, merge_en;
   logic            rd_valid, rd_dirty;
   logic [TAGW-1:0] rd_tag;
   logic [127:0]    rd_line;
   logic            hit;

   wire [IDXW-1:0] idx     = addr[OFFW+IDXW-1:OFFW];
   wire [TAGW-1:0] req_tag = addr[31:OFFW+IDXW];

   // Byte offset within a word is implied by wstrb.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^addr[1:0];

   dram_cache_store #(
      .LINES(LINES),
      .IDXW (IDXW),
      .TAGW (TAGW)
   ) u_store (
      .clk        (clk),
      .clear      (reset),
      .idx        (idx),
      .rd_valid   (rd_valid),
      .rd_dirty   (rd_dirty),
      .rd_tag     (rd_tag),
      .rd_line    (rd_line),
      .fill_en    (fill_en),
      .fill_tag   (req_tag),
      .fill_line  (mem_rdata),
      .merge_en   (merge_en),
      .merge_wsel (addr[3:2]),
      .merge_wstrb(wstrb),
      .merge_wdata(wdata)
   );

   assign hit       = rd_valid && (rd_tag == req_tag);
   assign mem_wdata = rd_line;  // the victim line; untouched while WBACK is pending
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_n;
         ready <= ready_n;
         rdata <= rdata_n;
      end
   end

   always_comb begin
      state_n   = state;
      ready_n   = 1'b0;
      rdata_n   = rdata;
      mem_valid = 1'b0;
      mem_wmask = 1'b0;
      mem_addr  = {addr[31:OFFW], 4'h0};
      fill_en   = 1'b0;
      merge_en  = 1'b0;
      case (state)
         IDLE: begin
            if (valid && !ready) begin
               if (hit) begin
                  ready_n = 1'b1;
                  if (wstrb == 4'b0000) rdata_n  = rd_line[{addr[3:2], 5'b00000} +: 32];
                  else                  merge_en = 1'b1;
               end else if (rd_valid && rd_dirty) begin
                  state_n = WBACK;
               end else begin
                  state_n = FILL;
               end
            end
         end
         WBACK: begin
            mem_valid = !mem_ready;
            mem_wmask = 1'b1;
            mem_addr  = {rd_tag, idx, 4'h0};
            if (mem_ready) state_n = FILL;
         end
         FILL: begin
            mem_valid = !mem_ready;
            // After the fill the request is replayed in IDLE, where it now hits.
            if (mem_ready) begin
               fill_en = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dram_cache.sv
// Self-checking bench for dram_cache: directed scenarios followed by random
// traffic, checked against a flat memory view plus a tag-level cache model.
module tb_dram_cache;
  import cache_defs::*;

  localparam int LINES = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic         ready;
  logic [31:0]  addr = '0;
  logic [3:0]   wstrb = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic         mem_wmask;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  cache_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected memory transactions: {wmask, addr[31:0], wdata[127:0]}.
  logic [160:0] exp_q[$];

  // Reference: DRAM contents, the core-visible memory, and tag-level cache state.
  logic [127:0] dram   [logic [27:0]];
  logic [127:0] golden [logic [27:0]];
  bit           m_valid [LINES];
  bit           m_dirty [LINES];
  logic [21:0]  m_tag   [LINES];

  dram_cache #(.LINES(LINES)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .ready    (ready),
    .addr     (addr),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .rdata    (rdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ensure_line(input logic [27:0] la);
    if (!dram.exists(la)) begin
      dram[la] = {$urandom, $urandom, $urandom, $urandom};
      golden[la] = dram[la];
    end
  endtask

  // Predicts memory traffic and the read value for one core access.
  task automatic model_access(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                              output logic [31:0] exp_rd, output bit was_hit);
    logic [27:0]  la;
    int           ix;
    logic [21:0]  tg;
    logic [27:0]  victim;
    int           w;
    la = a[31:4];
    ix = int'(la % LINES);
    tg = 22'(la / LINES);
    w  = int'(a[3:2]);
    ensure_line(la);
    was_hit = m_valid[ix] && (m_tag[ix] == tg);
    if (!was_hit) begin
      if (m_valid[ix] && m_dirty[ix]) begin
        victim = 28'(m_tag[ix]) * LINES + 28'(ix);
        exp_q.push_back({1'b1, victim, 4'h0, golden[victim]});
      end
      exp_q.push_back({1'b0, la, 4'h0, 128'h0});
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_dirty[ix] = 1'b0;
    end
    exp_rd = golden[la][32*w +: 32];
    if (ws != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) golden[la][32*w + 8*b +: 8] = wd[8*b +: 8];
      m_dirty[ix] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    foreach (dram[k]) golden[k] = dram[k];
    exp_q.delete();
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc, output bit timed_out);
    @(negedge clk);
    valid = 1'b1; addr = a; wstrb = ws; wdata = wd;
    cyc = 0; timed_out = 1'b1; rd = '0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        timed_out = 1'b0;
        rd = rdata;
        break;
      end
    end
    valid = 1'b0; wstrb = '0;
    @(posedge clk); #1;
    chk("ready_single_pulse", ready, 1'b0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          was_hit;
    int          cyc;
    bit          to;
    model_access(a, ws, wd, exp_rd, was_hit);
    do_req(a, ws, wd, rd, cyc, to);
    chk({tag, "_done"}, to, 1'b0);
    if (ws == 4'b0000) chk({tag, "_rdata"}, rd, exp_rd);
    if (was_hit) chk({tag, "_hit_latency"}, cyc, 1);
    else         chk({tag, "_miss_latency"}, cyc > 2, 1'b1);
  endtask

  // Controller model: random latency, field-stability checks, one-cycle mem_ready.
  initial begin
    logic [31:0]  cap_addr;
    logic         cap_wm;
    logic [127:0] cap_wd;
    logic [160:0] e;
    bit           abort;
    int           lat;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      if (mem_valid && !reset) begin
        cap_addr = mem_addr; cap_wm = mem_wmask; cap_wd = mem_wdata;
        abort = 1'b0;
        lat = $urandom_range(1, 4);
        for (int i = 0; i < lat; i++) begin
          @(negedge clk); #2;
          if (reset) begin
            abort = 1'b1;
            break;
          end
          chk("mem_valid_held", mem_valid, 1'b1);
          chk("mem_addr_stable", mem_addr, cap_addr);
          chk("mem_wmask_stable", mem_wmask, cap_wm);
          chk("mem_wdata_stable", mem_wdata, cap_wd);
        end
        if (!abort) begin
          chk("mem_txn_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mem_wmask", cap_wm, e[160]);
            chk("mem_addr", cap_addr, e[159:128]);
            chk("mem_addr_aligned", cap_addr[3:0], 4'h0);
            if (e[160]) chk("mem_wdata", cap_wd, e[127:0]);
          end
          if (cap_wm) dram[cap_addr[31:4]] = cap_wd;
          else mem_rdata = dram.exists(cap_addr[31:4]) ? dram[cap_addr[31:4]] : 128'h0;
          mem_ready = 1'b1;
          #1;
          chk("mem_valid_low_in_ready", mem_valid, 1'b0);
          @(negedge clk);
          mem_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  ws;
    logic [21:0] tags [4];
    logic [31:0] alt_addr [6];
    logic [3:0]  alt_ws [6];
    logic [31:0] exp_rd;
    bit          was_hit;
    int          cyc;
    bit          to;
    bit          seen_fill;

    tags = '{22'h0, 22'h1, 22'h3FFFFF, 22'h200000};
    alt_addr = '{32'h0000_03F0, 32'h0000_0400, 32'h0000_03F0, 32'h0000_0000, 32'h0000_07F4, 32'h0000_0404};
    alt_ws   = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    model_reset();
    dram[28'h10]   = 128'h33333333_22222222_11111111_00000000;
    golden[28'h10] = dram[28'h10];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_valid", mem_valid, 1'b0);
    chk("reset_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Cold read, write hit, read back, dirty eviction
    run("cold_read", 32'h0000_0104, 4'h0, 32'h0, rd);
    chk("cold_read_value", rd, 32'h11111111);
    run("write_hit", 32'h0000_0108, 4'b0011, 32'hDEADBEEF, rd);
    run("read_merged", 32'h0000_0108, 4'h0, 32'h0, rd);
    chk("read_merged_value", rd, 32'h2222BEEF);
    run("dirty_evict", 32'h0000_0508, 4'h0, 32'h0, rd);
    chk("evict_queue_drained", exp_q.size(), 0);

    // Reset during FILL abandons the fill
    model_access(32'h0000_0540, 4'h0, 32'h0, exp_rd, was_hit);
    @(negedge clk);
    valid = 1'b1; addr = 32'h0000_0540; wstrb = 4'h0;
    seen_fill = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == FILL) begin
        seen_fill = 1'b1;
        break;
      end
    end
    chk("reached_fill", seen_fill, 1'b1);
    valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("fill_reset_mem_valid", mem_valid, 1'b0);
    chk("fill_reset_ready", ready, 1'b0);
    chk("fill_reset_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    model_access(32'h0000_0540, 4'h0, 32'h0, exp_rd, was_hit);
    chk("model_reread_is_miss", was_hit, 1'b0);
    do_req(32'h0000_0540, 4'h0, 32'h0, rd, cyc, to);
    chk("reread_done", to, 1'b0);
    chk("reread_missed", cyc > 2, 1'b1);
    chk("reread_rdata", rd, exp_rd);

    // Index 63 and index 0 with distinct tags
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++)
        run("edge_idx", alt_addr[i], alt_ws[i], 32'hA5A5_0000 + 32'(i), rd);

    // Random traffic over a few conflicting tags, including extreme tag values
    for (int n = 0; n < 250; n++) begin
      a  = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, LINES - 1)), 2'($urandom_range(0, 3)), 2'b00};
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run("random", a, ws, $urandom, rd);
    end

    repeat (4) @(posedge clk);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dram_cache.md
# dram_cache

Direct-mapped, write-back, write-allocate cache that sits directly upstream of the DDR3 controller. It converts 32-bit word/byte accesses from the core's memory port into 128-bit line transactions on the controller's valid/ready port. Hits complete in one cycle. Misses evict the victim line (if dirty) and then fill the new line from DRAM.

## Interface
Parameters:
- LINES, 64: number of 16-byte lines; power of two, ≥ 2. IDXW = log2(LINES); TAGW = 28 − IDXW.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- valid  in  1  core request; held with addr/wstrb/wdata until ready
- ready  out  1  one-cycle completion pulse
- addr  in  32  byte address; [3:2] word select, [4+IDXW-1:4] index, [31:4+IDXW] tag
- wstrb  in  4  byte write enables; 0 = read
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready = 1
- mem_valid  out  1  line request to the controller
- mem_ready  in  1  one-cycle completion pulse from the controller
- mem_addr  out  32  16-byte-aligned byte address ([3:0] = 0)
- mem_wmask  out  1  1 = line write, 0 = line read
- mem_wdata  out  128  line write data; byte 0 is in bits [7:0]
- mem_rdata  in  128  line read data, valid while mem_ready = 1

## Operation
- Arrays: valid[LINES], dirty[LINES], tag[LINES][TAGW], data[LINES][128]. Reads are combinational; writes are registered.
- hit = valid[idx] && tag[idx] == addr tag.
- States: IDLE, WBACK, FILL.
- IDLE:
  - A request is accepted when valid && !ready.
  - On a hit, the cycle after acceptance has ready = 1. For a read, rdata = data[idx][32*addr[3:2] +: 32]. For a write, the strobed bytes are merged into the line and dirty[idx] is set; rdata is don't-care.
  - On a miss with a clean (or invalid) victim: go to FILL.
  - On a miss with valid && dirty victim: go to WBACK.
- WBACK:
  - mem_wmask = 1, mem_addr = {tag[idx], idx, 4'h0}, mem_wdata = data[idx].
  - On mem_ready: go to FILL.
- FILL:
  - mem_wmask = 0, mem_addr = {addr[31:4], 4'h0}.
  - On mem_ready: data[idx] ← mem_rdata, tag written, valid set, dirty cleared; go to IDLE.
  - The request is then re-evaluated in IDLE as a hit; a write merges at that point.
- mem_valid = (state == WBACK || state == FILL) && !mem_ready. It is combinationally dropped in the mem_ready cycle so the controller never sees a stale request on its next idle sample.
- mem_addr, mem_wmask and mem_wdata stay stable for the whole time mem_valid is asserted. The controller samples them several cycles after acceptance.
- The core request fields must stay stable until ready. If they change mid-miss, behaviour is undefined.
- Reset:
  - ready = 0, rdata = 0, state = IDLE, all valid and dirty bits = 0. tag and data are not reset.
  - Reset mid-WBACK or mid-FILL abandons the transaction, and dirty data is lost. The controller is reset by the same signal.

## Timing
- Read/write hit: acceptance edge, then ready the next cycle. Total 1 cycle, with back-to-back hits every 2 cycles.
- Clean miss: 1 cycle (IDLE→FILL) + controller fill latency + 1 cycle (FILL→IDLE) + 1 cycle hit.
- Dirty miss adds one full controller write transaction before the fill.
- ready is never asserted in two consecutive cycles. valid is ignored while ready = 1.
- mem_ready arriving in IDLE is ignored.
- Index 0 and index LINES−1 must behave identically; there is no wrap between lines. Tag compare covers all 32 − 4 − IDXW bits.

## Structure
- Shared package cache_defs: state encodings (IDLE = 2'd0, WBACK = 2'd1, FILL = 2'd2), LINE_BYTES = 16, OFFW = 4, the derived IDXW/TAGW expressions, and a byte-merge function (128-bit line, word select, wstrb, wdata).
- Sub-module cache_store holds the valid/dirty/tag/data arrays:
  - Read port: combinational on idx.
  - Write port: line fill (line + tag + clear dirty) or word merge (set dirty).
  - Clear input: invalidates all lines on reset.
- The top level holds the FSM and the handshake logic.

## Test plan
- Cold read of 0x0000_0104; model returns line 0x33333333_22222222_11111111_00000000 → one mem read at 0x0000_0100, mem_wmask = 0, then ready with rdata = 0x11111111.
- Write 0xDEADBEEF with wstrb = 4'b0011 to 0x0000_0108 after the fill → ready 1 cycle after acceptance, no mem traffic; a following read returns 0x2222BEEF.
- With LINES = 64, read 0x0000_0508 (same index 0x10, new tag) while the line is dirty → mem write at 0x0000_0100 carrying the merged line, then mem read at 0x0000_0500, then ready.
- Throughout these transactions, mem_valid is low in every mem_ready cycle, and mem_addr/mem_wdata/mem_wmask are constant while mem_valid = 1.
- Assert reset during FILL → the next cycle has mem_valid = 0, ready = 0, state IDLE; re-reading the same address misses again.
- Access index 63 (addr 0x0000_03F0) and index 0 alternately with distinct tags → there is no aliasing between them, and each returns its own fill data.
